// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm generator and its ramp sequencer:
// duty encodings, sequencer states and the default PWM period.
package pwm_pkg;

    localparam int PERIOD_CYCLES_DEF = 1000;

    typedef enum logic [1:0] {
        DUTY_25  = 2'b00,
        DUTY_50  = 2'b01,
        DUTY_75  = 2'b10,
        DUTY_100 = 2'b11
    } duty_t;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    // One duty level toward goal; saturates at both ends so the code never wraps.
    function automatic logic [1:0] step_toward(input logic [1:0] cur, input logic [1:0] goal);
        logic [1:0] nxt;
        nxt = cur;
        if (goal > cur && cur != DUTY_100) begin
            nxt = cur + 2'd1;
        end else if (goal < cur && cur != DUTY_25) begin
            nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pwm_period_cnt.sv
// Free-running PWM period counter, 0..PERIOD_CYCLES-1, with a registered
// flag that is high during the last cycle of every period.
module pwm_period_cnt
    import pwm_pkg::*;
#(
    parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEF,
    parameter int CNT_W         = 10
) (
    input  logic clk,
    input  logic reset,
    output logic period_end
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    assign cnt_next = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            period_end <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            period_end <= (cnt_next == CNT_LAST);
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer: walks the pwm duty select one level per
// PERIODS_PER_STEP PWM periods toward a target, changing only at period wrap.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int PERIOD_CYCLES    = PERIOD_CYCLES_DEF,
    parameter int PERIODS_PER_STEP = 4,
    parameter int CNT_W            = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] target,
    input  logic       abort,
    output logic [1:0] duty,
    output logic       busy,
    output logic       done,
    output logic       period_end
);

    localparam int STEP_W = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PERIODS_PER_STEP - 1);

    state_t            state;
    state_t            state_n;
    logic [1:0]        duty_n;
    logic [1:0]        tgt;
    logic [1:0]        tgt_n;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] step_n;
    logic              done_n;

    pwm_period_cnt #(
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .CNT_W         (CNT_W)
    ) u_period_cnt (
        .clk        (clk),
        .reset      (reset),
        .period_end (period_end)
    );

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_n = state;
        duty_n  = duty;
        tgt_n   = tgt;
        step_n  = step;
        done_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (target != duty) begin
                        tgt_n   = target;
                        step_n  = '0;
                        state_n = RAMP;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            RAMP: begin
                if (abort) begin
                    state_n = IDLE;
                    step_n  = '0;
                end else if (period_end) begin
                    if (step == STEP_LAST) begin
                        step_n = '0;
                        duty_n = step_toward(duty, tgt);
                        if (duty_n == tgt) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        step_n = step + STEP_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            duty  <= DUTY_25;
            tgt   <= DUTY_25;
            step  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            duty  <= duty_n;
            tgt   <= tgt_n;
            step  <= step_n;
            done  <= done_n;
        end
    end

    // The state is a single flop, so busy is a direct register output.
    assign busy = (state == RAMP);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed scenarios plus random
// traffic, compared each cycle against a period-counting reference model.
module tb_pwm_ramp_ctrl;

    localparam int P   = 8;
    localparam int PPS = 2;
    localparam int CW  = 3;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       start  = 1'b0;
    logic       abort  = 1'b0;
    logic [1:0] target = 2'b00;
    logic [1:0] duty;
    logic       busy;
    logic       done;
    logic       period_end;

    int n_checks = 0;
    int n_fail   = 0;
    int n_edge   = 0;
    int n_done   = 0;
    int chg_q[$];

    // Reference model: phase within the period, duty level, ramp goal and
    // the number of period ends seen since the ramp was accepted.
    int   m_cnt     = 0;
    int   m_duty    = 0;
    int   m_tgt     = 0;
    int   m_pe_seen = 0;
    logic m_busy    = 1'b0;
    logic m_done    = 1'b0;

    pwm_ramp_ctrl #(
        .PERIOD_CYCLES    (P),
        .PERIODS_PER_STEP (PPS),
        .CNT_W            (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .target     (target),
        .abort      (abort),
        .duty       (duty),
        .busy       (busy),
        .done       (done),
        .period_end (period_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, n_edge);
        end
    endtask

    task automatic model_reset();
        m_cnt     = 0;
        m_duty    = 0;
        m_tgt     = 0;
        m_pe_seen = 0;
        m_busy    = 1'b0;
        m_done    = 1'b0;
    endtask

    // One clock: drive inputs (called at a negedge), step the model on the
    // rising edge, then compare everything on the following falling edge.
    task automatic tick(input logic s, input logic [1:0] t, input logic a);
        logic       pe;
        logic [1:0] prev_duty;
        start     = s;
        target    = t;
        abort     = a;
        prev_duty = duty;
        @(posedge clk);
        n_edge++;
        pe     = (m_cnt == P - 1);
        m_cnt  = (m_cnt + 1) % P;
        m_done = 1'b0;
        if (m_busy) begin
            if (a) begin
                m_busy = 1'b0;
            end else if (pe) begin
                m_pe_seen++;
                if (m_pe_seen % PPS == 0) begin
                    m_duty = (m_tgt > m_duty) ? m_duty + 1 : m_duty - 1;
                    if (m_duty == m_tgt) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
        end else if (s && !a) begin
            if (int'(t) != m_duty) begin
                m_busy    = 1'b1;
                m_tgt     = int'(t);
                m_pe_seen = 0;
            end else begin
                m_done = 1'b1;
            end
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("duty", 4'(duty), 4'(m_duty));
        check("busy", 4'(busy), 4'(m_busy));
        check("done", 4'(done), 4'(m_done));
        check("period_end", 4'(period_end), 4'(m_cnt == P - 1));
        check("done_and_busy", 4'(done & busy), 4'd0);
        if (duty !== prev_duty) begin
            check("duty_edge_phase", 4'(m_cnt), 4'd0);
            chg_q.push_back(n_edge);
        end
        if (done === 1'b1) n_done++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 2'b00, 1'b0);
    endtask

    // Bounded by the model, so it always terminates even if the DUT hangs.
    task automatic run_until_idle(input int max_ticks);
        for (int i = 0; i < max_ticks && m_busy; i++) tick(1'b0, 2'b00, 1'b0);
        check("ramp_finished", 4'(busy), 4'd0);
    endtask

    task automatic clear_stats();
        chg_q.delete();
        n_done = 0;
    endtask

    // Edges from the start edge to the PPS-th period end that follows it.
    function automatic int first_step_edge(input int phase);
        int first_pe;
        first_pe = (phase < P - 1) ? (P - 1 - phase) : P;
        return first_pe + (PPS - 1) * P;
    endfunction

    initial begin
        int s_edge;
        int phase;
        logic s;
        logic a;
        logic [1:0] t;

        // Reset state
        @(negedge clk);
        check("rst_duty", 4'(duty), 4'd0);
        check("rst_busy", 4'(busy), 4'd0);
        check("rst_done", 4'(done), 4'd0);
        check("rst_period_end", 4'(period_end), 4'd0);
        reset = 1'b0;
        model_reset();

        // 1: 00 -> 11 with start sampled at cnt=3
        idle(3);
        clear_stats();
        tick(1'b1, 2'b11, 1'b0);
        s_edge = n_edge;
        for (int k = 1; k <= 45; k++) begin
            tick(1'b0, 2'b00, 1'b0);
            if (k == 11) check("t1_duty_11", 4'(duty), 4'd0);
            if (k == 12) check("t1_duty_12", 4'(duty), 4'd1);
            if (k == 27) check("t1_duty_27", 4'(duty), 4'd1);
            if (k == 28) check("t1_duty_28", 4'(duty), 4'd2);
            if (k == 43) check("t1_duty_43", 4'(duty), 4'd2);
            if (k < 44) check("t1_busy_high", 4'(busy), 4'd1);
            if (k == 44) begin
                check("t1_duty_44", 4'(duty), 4'd3);
                check("t1_done_44", 4'(done), 4'd1);
                check("t1_busy_44", 4'(busy), 4'd0);
            end
            if (k == 45) check("t1_done_45", 4'(done), 4'd0);
        end
        check("t1_done_count", 4'(n_done), 4'd1);
        check("t1_first_step", 8'(chg_q[0] - s_edge), 8'd12);

        // 2: 11 -> 00, one step per 16 edges
        idle(5);
        clear_stats();
        phase = m_cnt;
        tick(1'b1, 2'b00, 1'b0);
        s_edge = n_edge;
        run_until_idle(80);
        check("t2_duty", 4'(duty), 4'd0);
        check("t2_steps", 4'(chg_q.size()), 4'd3);
        if (chg_q.size() == 3) begin
            check("t2_first_step", 8'(chg_q[0] - s_edge), 8'(first_step_edge(phase)));
            check("t2_gap1", 8'(chg_q[1] - chg_q[0]), 8'd16);
            check("t2_gap2", 8'(chg_q[2] - chg_q[1]), 8'd16);
        end
        idle(2);
        check("t2_done_count", 4'(n_done), 4'd1);

        // 3: target equal to current duty (01)
        tick(1'b1, 2'b01, 1'b0);
        run_until_idle(40);
        idle(3);
        clear_stats();
        tick(1'b1, 2'b01, 1'b0);
        check("t3_done_p1", 4'(done), 4'd1);
        check("t3_busy_p1", 4'(busy), 4'd0);
        check("t3_duty_p1", 4'(duty), 4'd1);
        tick(1'b0, 2'b00, 1'b0);
        check("t3_done_p2", 4'(done), 4'd0);
        check("t3_busy_p2", 4'(busy), 4'd0);

        // 4: abort right after duty reaches 01, then resume to 10
        tick(1'b1, 2'b00, 1'b0);
        run_until_idle(40);
        tick(1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 40 && m_duty == 0; i++) tick(1'b0, 2'b00, 1'b0);
        clear_stats();
        tick(1'b0, 2'b00, 1'b1);
        check("t4_busy_abort", 4'(busy), 4'd0);
        check("t4_duty_abort", 4'(duty), 4'd1);
        check("t4_done_abort", 4'(done), 4'd0);
        idle(20);
        check("t4_frozen", 4'(chg_q.size()), 4'd0);
        check("t4_no_done", 4'(n_done), 4'd0);
        tick(1'b1, 2'b10, 1'b0);
        run_until_idle(40);
        check("t4_resumed_duty", 4'(duty), 4'd2);
        check("t4_resumed_steps", 4'(chg_q.size()), 4'd1);

        // 5: start while busy is ignored
        tick(1'b1, 2'b00, 1'b0);
        run_until_idle(80);
        clear_stats();
        tick(1'b1, 2'b11, 1'b0);
        idle(5);
        tick(1'b1, 2'b00, 1'b0);
        run_until_idle(80);
        check("t5_duty", 4'(duty), 4'd3);
        check("t5_done_count", 4'(n_done), 4'd1);

        // 6: asynchronous reset between edges, mid-ramp
        tick(1'b1, 2'b00, 1'b0);
        idle(20);
        #2 reset = 1'b1;
        #1;
        check("t6_duty", 4'(duty), 4'd0);
        check("t6_busy", 4'(busy), 4'd0);
        check("t6_done", 4'(done), 4'd0);
        check("t6_period_end", 4'(period_end), 4'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Random traffic against the model
        for (int i = 0; i < 700; i++) begin
            s = ($urandom_range(0, 7) == 0);
            a = ($urandom_range(0, 39) == 0);
            t = 2'($urandom_range(0, 3));
            tick(s, t, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
